move_input_ctrl: RTL and testbench
==================================

// Module: move_input_ctrl
// PURPOSE
//   Upstream stage of the game LOGIC block. Turns raw board switches SW into clean one-cycle
//   move commands (`RIGHT/`LEFT/`DOWN/`UP/`RESET, else `NONE) on the 100MHz clk.
//   Synchronizes and debounces the mapped switches and fires once per press (rising from all-idle).
//   Holds a latched command until LOGIC signals move_ready.
// PARAMETERS
//   DEBOUNCE_CYCLES  1_000_000  consecutive stable cycles before a switch level is accepted (10ms)
//   CNT_W            20         debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
//   clk         in   1   100MHz system clock; single clock domain
//   rstn        in   1   asynchronous, active-low reset
//   SW          in   16  raw switches; only SW[0],SW[1],SW[2],SW[3],SW[15] are used
//   move_ready  in   1   LOGIC can accept a move this cycle
//   move        out  3   move code (`PARAMS.v` encodings); `NONE except the single fire cycle
//   busy        out  1   high while a command is latched but not yet issued
// BEHAVIOUR
//   Reset (async, rstn=0): move=`NONE, busy=0, FSM=IDLE, sync FFs and debounced levels=0, counters=0.
//   Input path per mapped bit: 2-FF synchronizer, then debouncer. Debounced level takes the
//     synced value once it has differed from the current level for DEBOUNCE_CYCLES consecutive
//     cycles; any return to the current level clears the counter. SW[14:4] are ignored entirely.
//   any_db = OR of the 5 debounced levels; any_db_q = any_db registered one cycle.
//   Priority encode (debounced): SW0->`RIGHT, SW1->`LEFT, SW2->`DOWN, SW3->`UP, SW15->`RESET.
//   FSM (registered state, registered outputs):
//     IDLE: any_db && !any_db_q -> latch cmd=encode, go PEND. Else stay; move=`NONE.
//     PEND: busy=1. If move_ready: move=cmd for exactly one cycle, go HOLD. Else wait indefinitely.
//           Release of switches while in PEND does not cancel the latched cmd.
//     HOLD: move=`NONE; stay until any_db==0, then IDLE. Further presses/extra switches are
//           ignored until all mapped switches are debounced-released.
//   Latency: SW edge stable from cycle 0, move_ready=1 -> move pulse on cycle DEBOUNCE_CYCLES+4
//     (2 sync + DEBOUNCE_CYCLES + 1 edge detect + 1 output reg); bench checks exact cycle.
//   Simultaneous presses settling on the same cycle: highest-priority bit wins (SW0 first).
//   Presses settling on different cycles: the first settled edge fires; later ones are ignored.
//   Glitch shorter than DEBOUNCE_CYCLES: no debounced change, no move.
//   Never two consecutive non-`NONE cycles; at most one move per press/release cycle.
//   Reset mid-PEND/HOLD: cmd discarded, no move; after reset a still-held switch fires again
//     once debounced (debounced levels restart from 0).
// STRUCTURE
//   Shared `PARAMS.v`: move codes (`NONE,`RIGHT,`LEFT,`DOWN,`UP,`RESET), FSM state encodings
//     (IDLE/PEND/HOLD), default DEBOUNCE_CYCLES.
//   Sub-module debounce_bit (sync + counter + level, params DEBOUNCE_CYCLES/CNT_W), instanced x5.
//   Top-level: encoder, edge detect, FSM, output registers.
// TESTING (DEBOUNCE_CYCLES=4, CNT_W=3, move_ready=1 unless stated)
//   Reset: rstn=0 with SW=16'h0001 held -> move=`NONE, busy=0. Release rstn -> one `RIGHT
//     pulse 8 cycles later.
//   Single press: SW 0->16'h0004 at cycle 0 -> move=`DOWN only at cycle 8. No repeat while
//     held for 100 cycles. Release then press SW=16'h0008 -> exactly one `UP.
//   Bounce: SW[1] toggles every 2 cycles for 20 cycles, then holds 1 -> exactly one `LEFT,
//     4+4 cycles after the final settle.
//   Priority/ignore: SW=16'h8003 in one step -> one `RIGHT. SW=16'h0010 alone -> no move ever.
//   Handshake: move_ready=0, press SW[15] -> busy=1 from cycle 7. Release SW; assert move_ready
//     at cycle 30 -> `RESET on cycle 31; busy=0 from cycle 31.
//   Reset in PEND: move_ready=0, press SW[0], pulse rstn low in PEND -> no `RIGHT before reset.
//     After reset with SW still held -> one `RIGHT once move_ready=1.

Source files
------------

// File: rtl/move_input_ctrl_pkg.sv
// Shared definitions for the move input controller: move codes, FSM state
// encodings, default debounce settings and the switch-to-move priority encoder.
package move_input_ctrl_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int CNT_W_DEF           = 20;
  localparam int NUM_KEYS            = 5;

  // Key index order inside the controller: SW0, SW1, SW2, SW3, SW15.
  localparam int KEY_RIGHT = 0;
  localparam int KEY_LEFT  = 1;
  localparam int KEY_DOWN  = 2;
  localparam int KEY_UP    = 3;
  localparam int KEY_RESET = 4;

  typedef enum logic [2:0] {
    MOVE_NONE  = 3'd0,
    MOVE_RIGHT = 3'd1,
    MOVE_LEFT  = 3'd2,
    MOVE_DOWN  = 3'd3,
    MOVE_UP    = 3'd4,
    MOVE_RESET = 3'd5
  } move_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  function automatic move_e encode_move(input logic [NUM_KEYS-1:0] lvl);
    move_e m;
    m = MOVE_NONE;
    if (lvl[KEY_RIGHT])      m = MOVE_RIGHT;
    else if (lvl[KEY_LEFT])  m = MOVE_LEFT;
    else if (lvl[KEY_DOWN])  m = MOVE_DOWN;
    else if (lvl[KEY_UP])    m = MOVE_UP;
    else if (lvl[KEY_RESET]) m = MOVE_RESET;
    return m;
  endfunction

endpackage

// File: rtl/move_input_ctrl_debounce_bit.sv
// One switch input: 2-FF synchronizer followed by a consecutive-stability
// debouncer that only accepts a new level after DEBOUNCE_CYCLES differing cycles.
module debounce_bit
  import move_input_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic sw_i,
  output logic level_o
);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Any cycle where the synced value matches the current level restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/move_input_ctrl.sv
// Turns raw board switches into single-cycle move commands: five debounced
// inputs, rising-from-idle edge detect, and a latch/issue/hold FSM.
module move_input_ctrl
  import move_input_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] SW,
  input  logic        move_ready,
  output logic [2:0]  move,
  output logic        busy,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a latched command is presented to LOGIC as exactly one
  // non-NONE cycle of move, issued on the edge after move_ready is sampled
  // high while busy; busy drops on that same edge.

  logic [NUM_KEYS-1:0] raw_keys;
  logic [NUM_KEYS-1:0] db_lvl;
  logic                any_db;
  logic                any_db_q;
  logic                unused_sw;
  state_e              state_q;
  move_e               cmd_q;
  move_e               move_q;
  logic                busy_q;

  assign raw_keys  = {SW[15], SW[3:0]};
  assign unused_sw = ^SW[14:4];

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_db
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk    (clk),
      .rstn   (rstn),
      .sw_i   (raw_keys[k]),
      .level_o(db_lvl[k])
    );
  end

  assign any_db = |db_lvl;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      cmd_q    <= MOVE_NONE;
      move_q   <= MOVE_NONE;
      busy_q   <= 1'b0;
      any_db_q <= 1'b0;
    end else begin
      any_db_q <= any_db;
      move_q   <= MOVE_NONE;
      case (state_q)
        ST_IDLE: begin
          if (any_db && !any_db_q) begin
            cmd_q   <= encode_move(db_lvl);
            busy_q  <= 1'b1;
            state_q <= ST_PEND;
          end
        end
        // Switch release here does not cancel; the command waits for LOGIC.
        ST_PEND: begin
          if (move_ready) begin
            move_q  <= cmd_q;
            busy_q  <= 1'b0;
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!any_db) state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign move        = move_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_move_input_ctrl.sv
// Directed bench for move_input_ctrl with a short debounce window.
module tb_move_input_ctrl;

  localparam int D = 4;
  localparam logic [2:0] M_NONE  = 3'd0;
  localparam logic [2:0] M_RIGHT = 3'd1;
  localparam logic [2:0] M_LEFT  = 3'd2;
  localparam logic [2:0] M_DOWN  = 3'd3;
  localparam logic [2:0] M_UP    = 3'd4;
  localparam logic [2:0] M_RESET = 3'd5;
  localparam logic [1:0] S_IDLE  = 2'd0;

  logic        clk;
  logic        rstn;
  logic [15:0] SW;
  logic        move_ready;
  logic [2:0]  move;
  logic        busy;
  logic [1:0]  dbg_state;

  int checks;
  int errors;

  move_input_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .SW         (SW),
    .move_ready (move_ready),
    .move       (move),
    .busy       (busy),
    .dbg_state_o(dbg_state)
  );

  // clock block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge; values afterwards are "cycle n" values.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Release all switches and let the FSM drain back to IDLE.
  task automatic settle_idle(input string name);
    SW = 16'h0000;
    move_ready = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      checks++;
      if (move !== M_NONE) begin
        errors++;
        $display("FAIL %s_release cyc=%0d move=%0d exp=%0d", name, i, move, M_NONE);
      end
    end
    checks++;
    if (dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL %s_idle state=%0d exp=%0d", name, dbg_state, S_IDLE);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    SW = 16'h0001;
    move_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if (move !== M_NONE || busy !== 1'b0 || dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL reset_state move=%0d busy=%0b state=%0d exp=0/0/0", move, busy, dbg_state);
    end
    rstn = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if (move !== ((i == 8) ? M_RIGHT : M_NONE)) begin
        errors++;
        $display("FAIL reset_fire cyc=%0d move=%0d exp=%0d", i, move, (i == 8) ? M_RIGHT : M_NONE);
      end
      checks++;
      if (busy !== (i == 7)) begin
        errors++;
        $display("FAIL reset_busy cyc=%0d busy=%0b exp=%0b", i, busy, (i == 7));
      end
    end
    settle_idle("reset");
  endtask

  task automatic test_single_press();
    SW = 16'h0004;
    for (int i = 1; i <= 108; i++) begin
      tick();
      checks++;
      if (move !== ((i == 8) ? M_DOWN : M_NONE)) begin
        errors++;
        $display("FAIL down_press cyc=%0d move=%0d exp=%0d", i, move, (i == 8) ? M_DOWN : M_NONE);
      end
    end
    settle_idle("down");
    SW = 16'h0008;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if (move !== ((i == 8) ? M_UP : M_NONE)) begin
        errors++;
        $display("FAIL up_press cyc=%0d move=%0d exp=%0d", i, move, (i == 8) ? M_UP : M_NONE);
      end
    end
    settle_idle("up");
  endtask

  task automatic test_bounce();
    for (int t = 0; t < 10; t++) begin
      SW = (t % 2 == 0) ? 16'h0002 : 16'h0000;
      repeat (2) begin
        tick();
        checks++;
        if (move !== M_NONE || busy !== 1'b0) begin
          errors++;
          $display("FAIL bounce_glitch t=%0d move=%0d busy=%0b exp=0/0", t, move, busy);
        end
      end
    end
    SW = 16'h0002;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if (move !== ((i == 8) ? M_LEFT : M_NONE)) begin
        errors++;
        $display("FAIL bounce_fire cyc=%0d move=%0d exp=%0d", i, move, (i == 8) ? M_LEFT : M_NONE);
      end
    end
    settle_idle("bounce");
  endtask

  task automatic test_priority_ignore();
    SW = 16'h8003;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if (move !== ((i == 8) ? M_RIGHT : M_NONE)) begin
        errors++;
        $display("FAIL prio_fire cyc=%0d move=%0d exp=%0d", i, move, (i == 8) ? M_RIGHT : M_NONE);
      end
    end
    settle_idle("prio");
    SW = 16'h0010;
    for (int i = 1; i <= 30; i++) begin
      tick();
      checks++;
      if (move !== M_NONE || busy !== 1'b0) begin
        errors++;
        $display("FAIL ignored_bit cyc=%0d move=%0d busy=%0b exp=0/0", i, move, busy);
      end
    end
    settle_idle("ignored");
  endtask

  // Extra switches added while held must not produce another move.
  task automatic test_hold_ignore();
    SW = 16'h0001;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (move !== ((i == 8) ? M_RIGHT : M_NONE)) begin
        errors++;
        $display("FAIL hold_first cyc=%0d move=%0d exp=%0d", i, move, (i == 8) ? M_RIGHT : M_NONE);
      end
    end
    SW = 16'h0006;
    for (int i = 1; i <= 30; i++) begin
      tick();
      checks++;
      if (move !== M_NONE) begin
        errors++;
        $display("FAIL hold_extra cyc=%0d move=%0d exp=%0d", i, move, M_NONE);
      end
    end
    settle_idle("hold");
  endtask

  task automatic test_handshake();
    move_ready = 1'b0;
    SW = 16'h8000;
    for (int i = 1; i <= 36; i++) begin
      tick();
      checks++;
      if (move !== ((i == 31) ? M_RESET : M_NONE)) begin
        errors++;
        $display("FAIL hs_move cyc=%0d move=%0d exp=%0d", i, move, (i == 31) ? M_RESET : M_NONE);
      end
      checks++;
      if (busy !== (i >= 7 && i < 31)) begin
        errors++;
        $display("FAIL hs_busy cyc=%0d busy=%0b exp=%0b", i, busy, (i >= 7 && i < 31));
      end
      if (i == 10) SW = 16'h0000;
      if (i == 30) move_ready = 1'b1;
    end
    settle_idle("hs");
  endtask

  task automatic test_reset_in_pend();
    move_ready = 1'b0;
    SW = 16'h0001;
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks++;
      if (move !== M_NONE || busy !== (i >= 7)) begin
        errors++;
        $display("FAIL pend_wait cyc=%0d move=%0d busy=%0b exp=0/%0b", i, move, busy, (i >= 7));
      end
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || move !== M_NONE || dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL pend_async_rst move=%0d busy=%0b state=%0d exp=0/0/0", move, busy, dbg_state);
    end
    repeat (2) tick();
    move_ready = 1'b1;
    rstn = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if (move !== ((i == 8) ? M_RIGHT : M_NONE)) begin
        errors++;
        $display("FAIL pend_refire cyc=%0d move=%0d exp=%0d", i, move, (i == 8) ? M_RIGHT : M_NONE);
      end
    end
    settle_idle("pend");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_press();
    test_bounce();
    test_priority_ignore();
    test_hold_ignore();
    test_handshake();
    test_reset_in_pend();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
